// File: rtl/biriscv_decode_queue.sv
// Multi-lane decode and in-order instruction queue between fetch and issue.
// Optional BIRISCV_DECODE_PERF_EN adds a fetch-stall cycle counter on perf_stall_o.
module biriscv_decode_queue #(
   parameter int LANES = 2,
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       enable_muldiv_i,
   input  logic                       flush_i,
   input  logic [LANES-1:0]           fetch_valid_i,
   input  logic [32*LANES-1:0]        fetch_instr_i,
   input  logic [31:0]                fetch_pc_i,
   input  logic [LANES-1:0]           fetch_fault_i,
   output logic                       fetch_accept_o,
   output logic [LANES-1:0]           issue_valid_o,
   output logic [32*LANES-1:0]        issue_instr_o,
   output logic [32*LANES-1:0]        issue_pc_o,
   output logic [8*LANES-1:0]         issue_class_o,
   input  logic [LANES-1:0]           issue_accept_i,
   output logic [$clog2(DEPTH+1)-1:0] level_o,
   output logic [31:0]                perf_stall_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH+1);

   logic [31:0]      instr_q [DEPTH];
   logic [31:0]      pc_q    [DEPTH];
   logic [7:0]       class_q [DEPTH];
   logic [PTR_W-1:0] head_q;
   logic [PTR_W-1:0] tail_q;
   logic [LVL_W-1:0] level_q;
   logic [LVL_W-1:0] push_cnt;
   logic [LVL_W-1:0] pop_cnt;
   logic             push_en;

   // Class bits: {invalid, rd_valid, csr, div, mul, branch, lsu, exec}
   function automatic logic [7:0] decode(input logic [31:0] instr, input logic muldiv_en);
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      logic       exec, lsu, branch, mul, div, csr, rd_valid, legal;
      op = instr[6:0];
      f3 = instr[14:12];
      f7 = instr[31:25];
      exec = 1'b0; lsu = 1'b0; branch = 1'b0; mul = 1'b0;
      div = 1'b0; csr = 1'b0; rd_valid = 1'b0; legal = 1'b0;
      case (op)
         7'b0110111, 7'b0010111: begin
            legal = 1'b1; exec = 1'b1; rd_valid = 1'b1;
         end
         7'b0010011: begin
            legal = (f3 == 3'b001) ? (f7 == 7'b0000000) :
                    (f3 == 3'b101) ? (f7 == 7'b0000000 || f7 == 7'b0100000) : 1'b1;
            exec = legal; rd_valid = legal;
         end
         7'b0110011: begin
            if (f7 == 7'b0000001) begin
               legal = muldiv_en; mul = muldiv_en && !f3[2];
               div = muldiv_en && f3[2]; rd_valid = muldiv_en;
            end else begin
               legal = (f7 == 7'b0000000) ||
                       (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
               exec = legal; rd_valid = legal;
            end
         end
         7'b0000011: begin
            legal = (f3 != 3'b011) && (f3 != 3'b111); lsu = legal; rd_valid = legal;
         end
         7'b0100011: begin
            legal = !f3[2] && (f3 != 3'b011); lsu = legal;
         end
         7'b1101111: begin
            legal = 1'b1; branch = 1'b1; rd_valid = 1'b1;
         end
         7'b1100111: begin
            legal = (f3 == 3'b000); branch = legal; rd_valid = legal;
         end
         7'b1100011: begin
            legal = (f3 != 3'b010) && (f3 != 3'b011); branch = legal;
         end
         7'b0001111: begin
            legal = (f3 == 3'b000) || (f3 == 3'b001); csr = legal;
         end
         7'b1110011: begin
            if (f3 == 3'b000) begin
               // ECALL, EBREAK, MRET, WFI, SFENCE.VMA
               legal = (instr == 32'h00000073) || (instr == 32'h00100073) ||
                       (instr == 32'h30200073) || (instr == 32'h10500073) ||
                       (f7 == 7'b0001001 && instr[14:7] == 8'd0);
               csr = legal;
            end else begin
               legal = (f3 != 3'b100); csr = legal; rd_valid = legal;
            end
         end
         default: legal = 1'b0;
      endcase
      if (!legal)
         return 8'b1010_0000;
      return {1'b0, rd_valid, csr, div, mul, branch, lsu, exec};
   endfunction

   always_comb begin
      push_cnt = '0;
      pop_cnt  = '0;
      for (int k = 0; k < LANES; k++) begin
         push_cnt = push_cnt + LVL_W'(fetch_valid_i[k]);
         pop_cnt  = pop_cnt + LVL_W'(issue_accept_i[k]);
      end
   end

   // Accept decision uses the registered level only, so a same-cycle pop gives no credit.
   assign fetch_accept_o = (level_q <= LVL_W'(DEPTH - LANES));
   assign push_en        = fetch_valid_i[0] && fetch_accept_o;
   assign level_o        = level_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         level_q <= '0;
      end else begin
         if (push_en)
            tail_q <= tail_q + PTR_W'(push_cnt);
         head_q  <= head_q + PTR_W'(pop_cnt);
         level_q <= level_q + (push_en ? push_cnt : LVL_W'(0)) - pop_cnt;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_en && !flush_i && !rst_i) begin
         for (int k = 0; k < LANES; k++) begin
            if (fetch_valid_i[k]) begin
               instr_q[tail_q + PTR_W'(k)] <= fetch_instr_i[32*k +: 32];
               pc_q[tail_q + PTR_W'(k)]    <= fetch_pc_i + 32'(4 * k);
               class_q[tail_q + PTR_W'(k)] <= fetch_fault_i[k] ? 8'b0010_0000 :
                                              decode(fetch_instr_i[32*k +: 32], enable_muldiv_i);
            end
         end
      end
   end

   always_comb begin
      issue_valid_o = '0;
      issue_instr_o = '0;
      issue_pc_o    = '0;
      issue_class_o = '0;
      for (int k = 0; k < LANES; k++) begin
         issue_valid_o[k]         = (level_q > LVL_W'(k));
         issue_instr_o[32*k +: 32] = instr_q[head_q + PTR_W'(k)];
         issue_pc_o[32*k +: 32]    = pc_q[head_q + PTR_W'(k)];
         issue_class_o[8*k +: 8]   = class_q[head_q + PTR_W'(k)];
      end
   end

`ifdef BIRISCV_DECODE_PERF_EN
   logic [31:0] perf_stall_q;

   always_ff @(posedge clk_i) begin
      if (rst_i)
         perf_stall_q <= '0;
      else if (fetch_valid_i[0] && !fetch_accept_o && !flush_i)
         perf_stall_q <= perf_stall_q + 32'd1;
   end

   assign perf_stall_o = perf_stall_q;
`else
   assign perf_stall_o = 32'd0;
`endif

`ifndef SYNTHESIS
   // Pop mask must be a contiguous prefix of the valid lanes.
   always_ff @(posedge clk_i) begin
      if (!rst_i && !flush_i)
         assert (((issue_accept_i & ~issue_valid_o) == '0) &&
                 (((issue_accept_i + LANES'(1)) & issue_accept_i) == '0));
   end
`endif

endmodule

// File: tb/tb_biriscv_decode_queue.sv
// Scoreboard bench for biriscv_decode_queue: stimulus queues expected entries, a monitor checks pops.
module tb_biriscv_decode_queue;

   localparam logic [31:0] ADDI1 = 32'h00100093;
   localparam logic [31:0] ADDI5 = 32'h00128293;
   localparam logic [31:0] LW    = 32'h0000A103;
   localparam logic [31:0] MUL   = 32'h022081B3;
   localparam logic [31:0] DIV   = 32'h0220C1B3;
   localparam logic [31:0] ADD   = 32'h002081B3;
   localparam logic [31:0] SW    = 32'h0020A223;
   localparam logic [31:0] JAL   = 32'h000000EF;
   localparam logic [31:0] BEQ   = 32'h00000063;
   localparam logic [31:0] ECALL = 32'h00000073;
   localparam logic [31:0] CSRRW = 32'h300110F3;
   localparam logic [31:0] LUI   = 32'h123450B7;
   localparam logic [31:0] ILL   = 32'hFFFFFFFF;

`ifdef BIRISCV_DECODE_PERF_EN
   localparam logic [31:0] PERF_EXP = 32'd3;
`else
   localparam logic [31:0] PERF_EXP = 32'd0;
`endif

   logic        clk = 1'b0;
   logic        rst_i, enable_muldiv_i, flush_i, fetch_accept_o;
   logic [1:0]  fetch_valid_i, fetch_fault_i, issue_valid_o, issue_accept_i;
   logic [63:0] fetch_instr_i, issue_instr_o, issue_pc_o;
   logic [31:0] fetch_pc_i, perf_stall_o;
   logic [15:0] issue_class_o;
   logic [2:0]  level_o;

   biriscv_decode_queue #(.LANES(2), .DEPTH(4)) dut (
      .clk_i(clk), .rst_i(rst_i), .enable_muldiv_i(enable_muldiv_i), .flush_i(flush_i),
      .fetch_valid_i(fetch_valid_i), .fetch_instr_i(fetch_instr_i), .fetch_pc_i(fetch_pc_i),
      .fetch_fault_i(fetch_fault_i), .fetch_accept_o(fetch_accept_o),
      .issue_valid_o(issue_valid_o), .issue_instr_o(issue_instr_o), .issue_pc_o(issue_pc_o),
      .issue_class_o(issue_class_o), .issue_accept_i(issue_accept_i), .level_o(level_o),
      .perf_stall_o(perf_stall_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [7:0]  cls;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   lvl_m = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, update the reference model, then sample level after the edge.
   task automatic step(input logic [1:0] fv, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [31:0] pc, input logic [7:0] c0, input logic [7:0] c1,
                       input logic [1:0] ft, input logic [1:0] acc, input logic fl);
      int n;
      n = 0;
      fetch_valid_i  = fv;
      fetch_instr_i  = {i1, i0};
      fetch_pc_i     = pc;
      fetch_fault_i  = ft;
      issue_accept_i = acc;
      flush_i        = fl;
      if (rst_i || fl) begin
         exp_q.delete();
         lvl_m = 0;
      end else begin
         if (fv[0] && lvl_m <= 2) begin
            exp_q.push_back('{i0, pc, c0});
            n = 1;
            if (fv[1]) begin
               exp_q.push_back('{i1, pc + 32'd4, c1});
               n = 2;
            end
         end
         lvl_m = lvl_m + n - (int'(acc[0]) + int'(acc[1]));
      end
      @(posedge clk);
      #1;
      chk("level", 32'(level_o), 32'(lvl_m));
   endtask

   always @(negedge clk) begin
      if (!rst_i && !flush_i) begin
         for (int k = 0; k < 2; k++) begin
            if (issue_accept_i[k]) begin
               exp_t e;
               if (!issue_valid_o[k] || exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL pop_lane%0d: valid=%b queued=%0d, need a valid queued entry",
                           k, issue_valid_o[k], exp_q.size());
               end else begin
                  e = exp_q.pop_front();
                  chk($sformatf("instr_lane%0d", k), issue_instr_o[32*k +: 32], e.instr);
                  chk($sformatf("pc_lane%0d", k), issue_pc_o[32*k +: 32], e.pc);
                  chk($sformatf("class_lane%0d", k), 32'(issue_class_o[8*k +: 8]), 32'(e.cls));
               end
            end
         end
      end
   end

   logic [31:0] vec_i [4];
   logic [7:0]  vec_c [4];

   initial begin
      vec_i[0] = ADD; vec_c[0] = 8'h41;
      vec_i[1] = SW;  vec_c[1] = 8'h02;
      vec_i[2] = LUI; vec_c[2] = 8'h41;
      vec_i[3] = ILL; vec_c[3] = 8'hA0;

      rst_i = 1'b1; enable_muldiv_i = 1'b1; flush_i = 1'b0;
      fetch_valid_i = '0; fetch_instr_i = '0; fetch_pc_i = '0; fetch_fault_i = '0;
      issue_accept_i = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_level", 32'(level_o), 32'd0);
      chk("rst_valid", 32'(issue_valid_o), 32'd0);
      chk("rst_accept", 32'(fetch_accept_o), 32'd1);
      chk("rst_perf", perf_stall_o, 32'd0);
      rst_i = 1'b0;

      // Basic two-lane push and visibility one cycle later
      step(2'b11, ADDI1, LW, 32'h100, 8'h41, 8'h42, 2'b00, 2'b00, 1'b0);
      chk("t1_valid", 32'(issue_valid_o), 32'd3);
      chk("t1_class0", 32'(issue_class_o[7:0]), 32'h41);
      chk("t1_class1", 32'(issue_class_o[15:8]), 32'h42);
      chk("t1_pc0", issue_pc_o[31:0], 32'h100);
      chk("t1_pc1", issue_pc_o[63:32], 32'h104);
      step(2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b11, 1'b0);

      // Fill, then hold a third group for three stall cycles
      step(2'b11, ADD, SW, 32'h200, 8'h41, 8'h02, 2'b00, 2'b00, 1'b0);
      step(2'b11, JAL, BEQ, 32'h208, 8'h44, 8'h04, 2'b00, 2'b00, 1'b0);
      chk("t2_accept_full", 32'(fetch_accept_o), 32'd0);
      repeat (3) step(2'b11, LUI, ECALL, 32'h210, 8'h41, 8'h20, 2'b00, 2'b00, 1'b0);
      chk("t2_perf", perf_stall_o, PERF_EXP);
      step(2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b11, 1'b0);
      step(2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b11, 1'b0);
      chk("t2_accept_empty", 32'(fetch_accept_o), 32'd1);

      // M-extension gating, sampled at push time
      enable_muldiv_i = 1'b0;
      step(2'b01, MUL, 0, 32'h300, 8'hA0, 8'h00, 2'b00, 2'b00, 1'b0);
      chk("t3_mul_disabled", 32'(issue_class_o[7:0]), 32'hA0);
      step(2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b01, 1'b0);
      enable_muldiv_i = 1'b1;
      step(2'b11, MUL, DIV, 32'h304, 8'h48, 8'h50, 2'b00, 2'b00, 1'b0);
      enable_muldiv_i = 1'b0;
      step(2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b11, 1'b0);
      enable_muldiv_i = 1'b1;

      // Push+pop in the same cycle, then sustained traffic across pointer wrap
      step(2'b11, JAL, BEQ, 32'h400, 8'h44, 8'h04, 2'b00, 2'b00, 1'b0);
      step(2'b11, ECALL, CSRRW, 32'h408, 8'h20, 8'h60, 2'b00, 2'b01, 1'b0);
      chk("t4_level3", 32'(level_o), 32'd3);
      chk("t4_accept_level3", 32'(fetch_accept_o), 32'd0);
      step(2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b01, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(2'b11, vec_i[(2*i) % 4], vec_i[(2*i+1) % 4], 32'h500 + 32'(8*i),
              vec_c[(2*i) % 4], vec_c[(2*i+1) % 4], 2'b00, 2'b11, 1'b0);
      end
      step(2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b11, 1'b0);
      chk("t4_sb_drained", 32'(exp_q.size()), 32'd0);

      // Flush with a queue at level 3 and a pending push
      step(2'b11, ADD, LW, 32'h600, 8'h41, 8'h42, 2'b00, 2'b00, 1'b0);
      step(2'b01, LUI, 0, 32'h608, 8'h41, 8'h00, 2'b00, 2'b00, 1'b0);
      step(2'b01, ADDI5, 0, 32'h60C, 8'h41, 8'h00, 2'b00, 2'b00, 1'b1);
      chk("t5_valid", 32'(issue_valid_o), 32'd0);
      chk("t5_accept", 32'(fetch_accept_o), 32'd1);
      chk("t5_perf", perf_stall_o, PERF_EXP);
      step(2'b11, CSRRW, ADDI5, 32'h700, 8'h60, 8'h41, 2'b00, 2'b00, 1'b0);
      step(2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b11, 1'b0);

      // Fetch fault on lane 1, then reset in the middle of traffic
      step(2'b11, ADDI1, ADDI1, 32'h800, 8'h41, 8'h20, 2'b10, 2'b00, 1'b0);
      chk("t6_fault_class1", 32'(issue_class_o[15:8]), 32'h20);
      chk("t6_fault_instr1", issue_instr_o[63:32], ADDI1);
      step(2'b11, LW, SW, 32'h808, 8'h42, 8'h02, 2'b00, 2'b01, 1'b0);
      rst_i = 1'b1;
      step(2'b11, ADD, ADD, 32'h810, 8'h41, 8'h41, 2'b00, 2'b00, 1'b0);
      rst_i = 1'b0;
      chk("t6_rst_valid", 32'(issue_valid_o), 32'd0);
      chk("t6_rst_accept", 32'(fetch_accept_o), 32'd1);
      chk("t6_rst_perf", perf_stall_o, 32'd0);
      step(2'b11, BEQ, JAL, 32'h900, 8'h04, 8'h44, 2'b00, 2'b00, 1'b0);
      step(2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b11, 1'b0);
      chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
